// File: rtl/snake_step_scheduler_if.sv
// Step handshake between the snake step scheduler and the body store.
// The scheduler offers a proposed head position; the body store accepts it and reports self-collision.
interface snake_step_if #(
   parameter int X_W = 5,
   parameter int Y_W = 5
);
   logic           step_valid;
   logic           step_ready;
   logic           collision;
   logic [X_W-1:0] step_x;
   logic [Y_W-1:0] step_y;
   logic [3:0]     step_dir;

   modport master (
      output step_valid, step_x, step_y, step_dir,
      input  step_ready, collision
   );

   modport slave (
      input  step_valid, step_x, step_y, step_dir,
      output step_ready, collision
   );
endinterface

// File: rtl/snake_step_scheduler.sv
// Game-tick controller: paces head movement from the latched direction, applies edge handling,
// offers each step over a valid/ready handshake and runs the idle/running/game-over sequence.
module snake_step_scheduler #(
   parameter int TICK_DIV = 5000000,
   parameter int GRID_W   = 32,
   parameter int GRID_H   = 24,
   parameter int X_W      = 5,
   parameter int Y_W      = 5,
   parameter int START_X  = 16,
   parameter int START_Y  = 12,
   parameter int WRAP     = 1
) (
   input  logic           clock,
   input  logic           reset,
   input  logic [3:0]     direction,
   input  logic           enable,
   input  logic           restart,
   snake_step_if.master   step,
   output logic [X_W-1:0] head_x,
   output logic [Y_W-1:0] head_y,
   output logic           game_over,
   output logic [15:0]    step_count
);

   localparam int                CNT_W     = $clog2(TICK_DIV);
   localparam logic [CNT_W-1:0]  TICK_LAST = CNT_W'(TICK_DIV - 1);
   localparam logic [X_W-1:0]    X_START   = X_W'(START_X);
   localparam logic [Y_W-1:0]    Y_START   = Y_W'(START_Y);
   localparam logic [X_W-1:0]    X_LAST    = X_W'(GRID_W - 1);
   localparam logic [Y_W-1:0]    Y_LAST    = Y_W'(GRID_H - 1);

   typedef enum logic [1:0] {IDLE, WAIT_TICK, ISSUE, OVER} state_t;

   state_t           state, state_next;
   logic [CNT_W-1:0] tick_cnt;
   logic [X_W-1:0]   pend_x, next_x;
   logic [Y_W-1:0]   pend_y, next_y;
   logic [3:0]       pend_dir;
   logic             dir_legal, tick_hit, off_grid, handshake, take_step;

   assign dir_legal = (direction == 4'b0001) || (direction == 4'b0010) ||
                      (direction == 4'b0100) || (direction == 4'b1000);
   assign tick_hit  = (state == WAIT_TICK) && enable && (tick_cnt == TICK_LAST);
   assign handshake = (state == ISSUE) && step.step_ready;
   assign take_step = tick_hit && dir_legal && !off_grid;

   // Candidate head one cell along the requested axis; off_grid only matters when edges do not wrap.
   always_comb begin
      next_x   = head_x;
      next_y   = head_y;
      off_grid = 1'b0;
      case (direction)
         4'b0001: if (head_y == Y_LAST) begin
                     next_y   = '0;
                     off_grid = (WRAP == 0);
                  end else next_y = head_y + Y_W'(1);
         4'b0010: if (head_y == '0) begin
                     next_y   = Y_LAST;
                     off_grid = (WRAP == 0);
                  end else next_y = head_y - Y_W'(1);
         4'b0100: if (head_x == X_LAST) begin
                     next_x   = '0;
                     off_grid = (WRAP == 0);
                  end else next_x = head_x + X_W'(1);
         4'b1000: if (head_x == '0) begin
                     next_x   = X_LAST;
                     off_grid = (WRAP == 0);
                  end else next_x = head_x - X_W'(1);
         default: ;
      endcase
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:      if (dir_legal) state_next = WAIT_TICK;
         WAIT_TICK: if (tick_hit && dir_legal) state_next = off_grid ? OVER : ISSUE;
         ISSUE:     if (handshake) state_next = step.collision ? OVER : WAIT_TICK;
         OVER:      if (restart) state_next = IDLE;
         default:   state_next = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_next;
   end

   // The tick counter only advances while waiting; every other state parks it at zero.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         tick_cnt   <= '0;
         pend_x     <= X_START;
         pend_y     <= Y_START;
         pend_dir   <= 4'b0000;
         head_x     <= X_START;
         head_y     <= Y_START;
         step_count <= 16'd0;
      end else begin
         if (state != WAIT_TICK)
            tick_cnt <= '0;
         else if (enable)
            tick_cnt <= tick_hit ? '0 : tick_cnt + CNT_W'(1);

         if (take_step) begin
            pend_x   <= next_x;
            pend_y   <= next_y;
            pend_dir <= direction;
         end

         if (handshake) begin
            head_x <= pend_x;
            head_y <= pend_y;
            if (step_count != 16'hFFFF) step_count <= step_count + 16'd1;
         end

         if ((state == OVER) && restart) begin
            pend_x     <= X_START;
            pend_y     <= Y_START;
            pend_dir   <= 4'b0000;
            head_x     <= X_START;
            head_y     <= Y_START;
            step_count <= 16'd0;
         end
      end
   end

   assign step.step_valid = (state == ISSUE);
   assign step.step_x     = pend_x;
   assign step.step_y     = pend_y;
   assign step.step_dir   = pend_dir;
   assign game_over       = (state == OVER);

endmodule
